// File: rtl/spi_cfg_regfile.sv
// SPI-slave (mode 0) configuration register file: NUM_REGS x DATA_W registers,
// atomic writes, MISO read-back, malformed frames rejected and counted.
module spi_cfg_regfile #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = {72'h0, 24'h507380}
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         SCK,
  input  logic                         MOSI,
  input  logic                         CS,
  output logic                         MISO,
  output logic                         MISO_OE,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_flat,
  output logic                         upd,
  output logic [ADDR_W-1:0]            upd_addr,
  output logic                         busy,
  output logic [7:0]                   err_cnt
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int unsigned HDR_LEN   = 1 + ADDR_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_HDR  = CNT_W'(HDR_LEN);
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, mosi_s, cs_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [FRAME_LEN-1:0]   rx_sr;
  logic [DATA_W-1:0]      tx_sr;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  logic [ADDR_W-1:0]      hdr_addr, commit_addr;
  logic                   commit_rw, frame_ok;
  logic [DATA_W-1:0]      rd_word, commit_data;

  // CS chain resets high so a released reset never looks like a CS fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  assign hdr_addr    = rx_sr[ADDR_W-1:0];
  assign commit_rw   = rx_sr[FRAME_LEN-1];
  assign commit_addr = rx_sr[FRAME_LEN-2 -: ADDR_W];
  assign commit_data = rx_sr[DATA_W-1:0];
  assign frame_ok    = (cnt == CNT_FULL) && ({1'b0, commit_addr} < NREGS);

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_word = regs[i];
    end
  end

  always_comb begin
    cfg_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cfg_flat[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  assign busy = (state != IDLE);
  assign MISO = tx_sr[DATA_W-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      MISO_OE  <= 1'b0;
      upd      <= 1'b0;
      upd_addr <= '0;
      err_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= CMD;
            cnt   <= '0;
            rx_sr <= '0;
          end
        end
        CMD, DATA: begin
          // CS edges win over a coincident SCK edge.
          if (cs_rise) begin
            state   <= DONE;
            tx_sr   <= '0;
            MISO_OE <= 1'b0;
          end else if (!cs_s) begin
            if (sck_rise) begin
              rx_sr <= {rx_sr[FRAME_LEN-2:0], mosi_s};
              if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
            end else if (sck_fall) begin
              if (state == CMD && cnt == CNT_HDR) begin
                state <= DATA;
                if (rx_sr[ADDR_W]) begin
                  tx_sr   <= rd_word;
                  MISO_OE <= 1'b1;
                end
              end else if (state == DATA && MISO_OE) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          if (frame_ok) begin
            if (!commit_rw) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (commit_addr == ADDR_W'(i)) regs[i] <= commit_data;
              end
              upd      <= 1'b1;
              upd_addr <= commit_addr;
            end
          end else if (err_cnt != '1) begin
            err_cnt <= err_cnt + 8'd1;
          end
          if (cs_fall) begin
            state <= CMD;
            cnt   <= '0;
            rx_sr <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
